reduce_engine_strided: RTL and testbench

//  Parametrised, pipelined row-reduction engine for the graph datapath: reduces outer_count rows of

---
 rtl/graph_isa_pkg.sv | 34 +++
 rtl/reduce_div_seq.sv | 67 ++++++
 rtl/reduce_engine_strided.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_reduce_engine_strided.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/graph_isa_pkg.sv
// Graph datapath ISA definitions shared by the graph engines.
// Holds the reduce-engine opcodes, the latched command payload layout and
// a legality helper used by the command front end.
package graph_isa_pkg;

    localparam int unsigned GRAPH_OP_W   = 8;
    localparam int unsigned CMD_FIELD_W  = 16;
    localparam int unsigned CMD_SHIFT_W  = 5;

    // Reduction opcodes
    localparam logic [GRAPH_OP_W-1:0] OP_G_REDUCE_SUM    = 8'h40;
    localparam logic [GRAPH_OP_W-1:0] OP_G_REDUCE_MEAN   = 8'h41;
    localparam logic [GRAPH_OP_W-1:0] OP_G_REDUCE_MAX    = 8'h42;
    localparam logic [GRAPH_OP_W-1:0] OP_G_REDUCE_MIN    = 8'h43;
    localparam logic [GRAPH_OP_W-1:0] OP_G_REDUCE_ARGMAX = 8'h44;

    // Command fields kept for the whole command (source base lives in the row pointer)
    typedef struct packed {
        logic [GRAPH_OP_W-1:0]  opcode;
        logic [CMD_FIELD_W-1:0] dst_base;
        logic [CMD_FIELD_W-1:0] reduce_dim;
        logic [CMD_FIELD_W-1:0] outer_count;
        logic [CMD_FIELD_W-1:0] inner_stride;
        logic [CMD_FIELD_W-1:0] outer_stride;
        logic [CMD_SHIFT_W-1:0] shift;
    } re_cmd_t;

    function automatic logic is_reduce_op(input logic [GRAPH_OP_W-1:0] op);
        return (op == OP_G_REDUCE_SUM)  || (op == OP_G_REDUCE_MEAN) ||
               (op == OP_G_REDUCE_MAX)  || (op == OP_G_REDUCE_MIN)  ||
               (op == OP_G_REDUCE_ARGMAX);
    endfunction

endpackage

// File: rtl/reduce_div_seq.sv
// Unsigned restoring divider, one quotient bit per cycle.
// Ports: clk, rst_n; start (loads operands); dividend/divisor (sampled on start);
//        busy (iterating); done (1-cycle pulse, ACC_W cycles after start);
//        quotient (valid from done until the next start).
module reduce_div_seq #(
    parameter int unsigned ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ACC_W-1:0] dividend,
    input  logic [ACC_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] quotient
);

    localparam int unsigned CNT_W = $clog2(ACC_W + 1);

    logic [ACC_W-1:0] rem;
    logic [ACC_W-1:0] quo;
    logic [ACC_W-1:0] dvs;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W:0]   trial_c;

    // Trial subtraction; MSB set means the partial remainder was smaller than the divisor
    always_comb begin
        trial_c = {rem, quo[ACC_W-1]} - {1'b0, dvs};
    end

    // Iteration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem  <= '0;
            quo  <= '0;
            dvs  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem  <= '0;
                quo  <= dividend;
                dvs  <= divisor;
                cnt  <= CNT_W'(ACC_W);
                busy <= 1'b1;
            end else if (busy) begin
                if (!trial_c[ACC_W]) begin
                    rem <= trial_c[ACC_W-1:0];
                    quo <= {quo[ACC_W-2:0], 1'b1};
                end else begin
                    rem <= {rem[ACC_W-2:0], quo[ACC_W-1]};
                    quo <= {quo[ACC_W-2:0], 1'b0};
                end
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo;

endmodule

// File: rtl/reduce_engine_strided.sv
// Strided row-reduction engine: reduces outer_count rows of reduce_dim elements
// read from SRAM0 into one DATA_W result per row (SUM/MEAN/MAX/MIN/ARGMAX).
// Ports: clk, rst_n; cmd_* valid/ready command port; sram_rd_* read request
//        (data one cycle later on sram_rd_data); sram_wr_* result write;
//        busy (not idle), done (end-of-command pulse), err (pulse with done on
//        an illegal command).
module reduce_engine_strided
    import graph_isa_pkg::*;
#(
    parameter int unsigned SRAM0_AW = 16,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ACC_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [7:0]          cmd_opcode,
    input  logic [15:0]         cmd_src_base,
    input  logic [15:0]         cmd_dst_base,
    input  logic [15:0]         cmd_reduce_dim,
    input  logic [15:0]         cmd_outer_count,
    input  logic [15:0]         cmd_inner_stride,
    input  logic [15:0]         cmd_outer_stride,
    input  logic [4:0]          cmd_shift,
    output logic                sram_rd_en,
    output logic [SRAM0_AW-1:0] sram_rd_addr,
    input  logic [DATA_W-1:0]   sram_rd_data,
    output logic                sram_wr_en,
    output logic [SRAM0_AW-1:0] sram_wr_addr,
    output logic [DATA_W-1:0]   sram_wr_data,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int unsigned IDX_W   = 16;
    localparam int unsigned IDX_MAX = (2 ** DATA_W) - 1;

    localparam logic signed [ACC_W:0] D_MAX = (ACC_W+1)'((2 ** (DATA_W-1)) - 1);
    localparam logic signed [ACC_W:0] D_MIN = ~D_MAX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DIV,
        S_WRITE,
        S_DONE
    } re_state_t;

    re_state_t             state;
    re_cmd_t               cmd_q;
    logic [15:0]           row;
    logic [15:0]           k;
    logic [SRAM0_AW-1:0]   row_ptr;

    logic                  rd_s1;       // SRAM data valid on sram_rd_data this cycle
    logic                  rd_s2;       // rd_data_q holds a datum to accumulate
    logic [DATA_W-1:0]     rd_data_q;

    logic signed [ACC_W-1:0] acc;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        cnt;        // data consumed in the current row

    logic signed [ACC_W-1:0] d_ext_c;
    logic signed [ACC_W-1:0] acc_upd_c;
    logic [IDX_W-1:0]        idx_upd_c;
    logic [DATA_W-1:0]       res_acc_c;
    logic [DATA_W-1:0]       res_mean_c;
    logic [ACC_W-1:0]        abs_acc_c;
    logic signed [ACC_W:0]   q_signed_c;

    logic                    div_start_c;
    logic [ACC_W-1:0]        div_dividend_c;
    logic [ACC_W-1:0]        div_divisor_c;
    logic                    div_busy;
    logic                    div_done;
    logic [ACC_W-1:0]        div_quotient;

    function automatic logic [DATA_W-1:0] sat_to_data(input logic signed [ACC_W:0] x);
        if (x > D_MAX) return D_MAX[DATA_W-1:0];
        if (x < D_MIN) return D_MIN[DATA_W-1:0];
        return x[DATA_W-1:0];
    endfunction

    // Round-half-up arithmetic right shift; one guard bit keeps the bias add from overflowing
    function automatic logic signed [ACC_W:0] rshift_round(input logic signed [ACC_W-1:0] a,
                                                           input logic [4:0]              sh);
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a};
        if (sh != 5'd0) s = s + ((ACC_W+1)'(1) << (sh - 5'd1));
        return s >>> sh;
    endfunction

    function automatic logic signed [ACC_W-1:0] acc_init(input logic [7:0] op);
        case (op)
            OP_G_REDUCE_MAX: return {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
            OP_G_REDUCE_MIN: return {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
            default:         return '0;
        endcase
    endfunction

    // Accumulator update for the datum sitting in the read pipe
    always_comb begin
        acc_upd_c = acc;
        idx_upd_c = idx;
        d_ext_c   = ACC_W'($signed(rd_data_q));
        if (rd_s2) begin
            case (cmd_q.opcode)
                OP_G_REDUCE_SUM, OP_G_REDUCE_MEAN: acc_upd_c = acc + d_ext_c;
                OP_G_REDUCE_MAX: if (d_ext_c > acc) acc_upd_c = d_ext_c;
                OP_G_REDUCE_MIN: if (d_ext_c < acc) acc_upd_c = d_ext_c;
                OP_G_REDUCE_ARGMAX: begin
                    // Strict compare keeps the first maximum
                    if (cnt == '0 || d_ext_c > acc) begin
                        acc_upd_c = d_ext_c;
                        idx_upd_c = cnt;
                    end
                end
                default: ;
            endcase
        end
    end

    // Row result for the non-divider modes, from the final accumulator value
    always_comb begin
        res_acc_c = '0;
        case (cmd_q.opcode)
            OP_G_REDUCE_SUM:  res_acc_c = sat_to_data(rshift_round(acc_upd_c, cmd_q.shift));
            OP_G_REDUCE_MAX,
            OP_G_REDUCE_MIN:  res_acc_c = acc_upd_c[DATA_W-1:0];
            OP_G_REDUCE_ARGMAX: begin
                if (32'(idx_upd_c) > IDX_MAX) res_acc_c = '1;
                else                          res_acc_c = DATA_W'(idx_upd_c);
            end
            default: ;
        endcase
    end

    // MEAN: divide |acc| + dim/2 by dim, then restore the sign (half away from zero)
    always_comb begin
        abs_acc_c      = acc_upd_c[ACC_W-1] ? ACC_W'(-acc_upd_c) : ACC_W'(acc_upd_c);
        div_dividend_c = abs_acc_c + ACC_W'(cmd_q.reduce_dim >> 1);
        div_divisor_c  = ACC_W'(cmd_q.reduce_dim);
        div_start_c    = (state == S_DRAIN) && !rd_s1 && (cmd_q.opcode == OP_G_REDUCE_MEAN);
        q_signed_c     = {1'b0, div_quotient};
        if (acc[ACC_W-1]) q_signed_c = -q_signed_c;
        res_mean_c     = sat_to_data(q_signed_c);
    end

    reduce_div_seq #(
        .ACC_W (ACC_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start_c),
        .dividend (div_dividend_c),
        .divisor  (div_divisor_c),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quotient)
    );

    // Control FSM, read pipe and accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cmd_q        <= '0;
            row          <= '0;
            k            <= '0;
            row_ptr      <= '0;
            rd_s1        <= 1'b0;
            rd_s2        <= 1'b0;
            rd_data_q    <= '0;
            acc          <= '0;
            idx          <= '0;
            cnt          <= '0;
            cmd_ready    <= 1'b1;
            sram_rd_en   <= 1'b0;
            sram_rd_addr <= '0;
            sram_wr_en   <= 1'b0;
            sram_wr_addr <= '0;
            sram_wr_data <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            rd_s1 <= sram_rd_en;
            rd_s2 <= rd_s1;
            if (rd_s1) rd_data_q <= sram_rd_data;
            if (rd_s2) begin
                acc <= acc_upd_c;
                idx <= idx_upd_c;
                cnt <= cnt + IDX_W'(1);
            end
            sram_wr_en <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cmd_q     <= '{opcode:       cmd_opcode,
                                       dst_base:     cmd_dst_base,
                                       reduce_dim:   cmd_reduce_dim,
                                       outer_count:  cmd_outer_count,
                                       inner_stride: cmd_inner_stride,
                                       outer_stride: cmd_outer_stride,
                                       shift:        cmd_shift};
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        row       <= '0;
                        row_ptr   <= SRAM0_AW'(cmd_src_base);
                        if (cmd_reduce_dim == '0 || cmd_outer_count == '0 ||
                            !is_reduce_op(cmd_opcode)) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state        <= S_ISSUE;
                            sram_rd_en   <= 1'b1;
                            sram_rd_addr <= SRAM0_AW'(cmd_src_base);
                            k            <= '0;
                            acc          <= acc_init(cmd_opcode);
                            idx          <= '0;
                            cnt          <= '0;
                        end
                    end
                end

                S_ISSUE: begin
                    if (k == cmd_q.reduce_dim - 16'd1) begin
                        sram_rd_en <= 1'b0;
                        state      <= S_DRAIN;
                    end else begin
                        k            <= k + 16'd1;
                        sram_rd_addr <= sram_rd_addr + SRAM0_AW'(cmd_q.inner_stride);
                    end
                end

                // Wait until the last datum has left the SRAM and is being accumulated
                S_DRAIN: begin
                    if (!rd_s1) begin
                        if (cmd_q.opcode == OP_G_REDUCE_MEAN) begin
                            state <= S_DIV;
                        end else begin
                            state        <= S_WRITE;
                            sram_wr_en   <= 1'b1;
                            sram_wr_addr <= SRAM0_AW'(cmd_q.dst_base) + SRAM0_AW'(row);
                            sram_wr_data <= res_acc_c;
                        end
                    end
                end

                S_DIV: begin
                    if (div_done && !div_busy) begin
                        state        <= S_WRITE;
                        sram_wr_en   <= 1'b1;
                        sram_wr_addr <= SRAM0_AW'(cmd_q.dst_base) + SRAM0_AW'(row);
                        sram_wr_data <= res_mean_c;
                    end
                end

                S_WRITE: begin
                    if (row == cmd_q.outer_count - 16'd1) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        row          <= row + 16'd1;
                        row_ptr      <= row_ptr + SRAM0_AW'(cmd_q.outer_stride);
                        state        <= S_ISSUE;
                        sram_rd_en   <= 1'b1;
                        sram_rd_addr <= row_ptr + SRAM0_AW'(cmd_q.outer_stride);
                        k            <= '0;
                        acc          <= acc_init(cmd_q.opcode);
                        idx          <= '0;
                        cnt          <= '0;
                    end
                end

                S_DONE: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reduce_engine_strided.sv
// Directed bench for reduce_engine_strided with an SRAM model and a write scoreboard.
module tb_reduce_engine_strided;
    import graph_isa_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode = '0;
    logic [15:0] cmd_src_base = '0;
    logic [15:0] cmd_dst_base = '0;
    logic [15:0] cmd_reduce_dim = '0;
    logic [15:0] cmd_outer_count = '0;
    logic [15:0] cmd_inner_stride = '0;
    logic [15:0] cmd_outer_stride = '0;
    logic [4:0]  cmd_shift = '0;
    logic        sram_rd_en;
    logic [15:0] sram_rd_addr;
    logic [7:0]  sram_rd_data = '0;
    logic        sram_wr_en;
    logic [15:0] sram_wr_addr;
    logic [7:0]  sram_wr_data;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    int busy_cyc = 0;
    int rd_cyc = 0;
    int done_cnt = 0;

    logic [15:0] exp_addr_q[$];
    logic [7:0]  exp_data_q[$];
    logic [7:0]  mem [0:65535];

    reduce_engine_strided dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_opcode       (cmd_opcode),
        .cmd_src_base     (cmd_src_base),
        .cmd_dst_base     (cmd_dst_base),
        .cmd_reduce_dim   (cmd_reduce_dim),
        .cmd_outer_count  (cmd_outer_count),
        .cmd_inner_stride (cmd_inner_stride),
        .cmd_outer_stride (cmd_outer_stride),
        .cmd_shift        (cmd_shift),
        .sram_rd_en       (sram_rd_en),
        .sram_rd_addr     (sram_rd_addr),
        .sram_rd_data     (sram_rd_data),
        .sram_wr_en       (sram_wr_en),
        .sram_wr_addr     (sram_wr_addr),
        .sram_wr_data     (sram_wr_data),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    always #5 clk = ~clk;

    // SRAM model: read data valid the cycle after the request
    always @(posedge clk) begin
        if (sram_rd_en) sram_rd_data <= mem[sram_rd_addr];
        if (sram_wr_en) mem[sram_wr_addr] <= sram_wr_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] addr, input logic [7:0] data);
        exp_addr_q.push_back(addr);
        exp_data_q.push_back(data);
    endtask

    // Monitor: counters plus scoreboard comparison of every result write
    always @(negedge clk) begin
        logic [15:0] ea;
        logic [7:0]  ed;
        busy_cyc = busy_cyc + int'(busy);
        rd_cyc   = rd_cyc + int'(sram_rd_en);
        if (done) done_cnt++;
        if (sram_wr_en) begin
            if (exp_addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0h data %0h, none expected", sram_wr_addr, sram_wr_data);
            end else begin
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                check("wr_addr", 32'(sram_wr_addr), 32'(ea));
                check("wr_data", 32'(sram_wr_data), 32'(ed));
            end
        end
    end

    task automatic start_cmd(input logic [7:0] op, input logic [15:0] src, input logic [15:0] dst,
                             input logic [15:0] dim, input logic [15:0] rows, input logic [15:0] istr,
                             input logic [15:0] ostr, input logic [4:0] sh);
        @(negedge clk);
        cmd_opcode       = op;
        cmd_src_base     = src;
        cmd_dst_base     = dst;
        cmd_reduce_dim   = dim;
        cmd_outer_count  = rows;
        cmd_inner_stride = istr;
        cmd_outer_stride = ostr;
        cmd_shift        = sh;
        cmd_valid        = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input logic exp_err);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 3000);
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_err"}, 32'(err), 32'(exp_err));
        @(negedge clk);
        check({name, "_post_done"}, {29'd0, busy, done, cmd_ready}, 32'b001);
    endtask

    task automatic run_cmd(input string name, input logic [7:0] op, input logic [15:0] src,
                           input logic [15:0] dst, input logic [15:0] dim, input logic [15:0] rows,
                           input logic [15:0] istr, input logic [15:0] ostr, input logic [4:0] sh,
                           input logic exp_err);
        start_cmd(op, src, dst, dim, rows, istr, ostr, sh);
        wait_done(name, exp_err);
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        // SUM rows {1,2,3,4} and {-1,-2,-3,-4}
        mem[16'h0100] = 8'd1;   mem[16'h0101] = 8'd2;   mem[16'h0102] = 8'd3;   mem[16'h0103] = 8'd4;
        mem[16'h0104] = 8'hFF;  mem[16'h0105] = 8'hFE;  mem[16'h0106] = 8'hFD;  mem[16'h0107] = 8'hFC;
        // 100 x4, -128 x4
        for (int i = 0; i < 4; i++) begin
            mem[16'h0700 + 16'(i)] = 8'd100;
            mem[16'h0704 + 16'(i)] = 8'h80;
        end
        // MEAN rows {1,1,2}, {-1,-1,-2}, then {1,2}
        mem[16'h0400] = 8'd1;   mem[16'h0401] = 8'd1;   mem[16'h0402] = 8'd2;
        mem[16'h0403] = 8'hFF;  mem[16'h0404] = 8'hFF;  mem[16'h0405] = 8'hFE;
        mem[16'h0410] = 8'd1;   mem[16'h0411] = 8'd2;
        // {3,9,-2,9,0}
        mem[16'h0500] = 8'd3;   mem[16'h0501] = 8'd9;   mem[16'h0502] = 8'hFE;
        mem[16'h0503] = 8'd9;   mem[16'h0504] = 8'd0;
        // Wrapping MAX: 0xFFFE, 0x0000, 0x0002 (0xFFFF is a decoy)
        mem[16'hFFFE] = 8'd5;   mem[16'hFFFF] = 8'd100; mem[16'h0000] = 8'd20; mem[16'h0002] = 8'hF9;
        // Throughput rows: 1..24
        for (int i = 0; i < 24; i++) mem[16'h0300 + 16'(i)] = 8'(i + 1);

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outputs", {26'd0, cmd_ready, busy, done, err, sram_rd_en, sram_wr_en}, 32'b100000);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {29'd0, cmd_ready, busy, sram_rd_en}, 32'b100);

        // SUM two rows
        push_exp(16'h0200, 8'd10);
        push_exp(16'h0201, 8'hF6);
        run_cmd("sum_2rows", OP_G_REDUCE_SUM, 16'h0100, 16'h0200, 16'd4, 16'd2, 16'd1, 16'd4, 5'd0, 1'b0);

        // SUM saturation and rounded shift
        push_exp(16'h0210, 8'h7F);
        run_cmd("sum_sat_hi", OP_G_REDUCE_SUM, 16'h0700, 16'h0210, 16'd4, 16'd1, 16'd1, 16'd0, 5'd0, 1'b0);
        push_exp(16'h0211, 8'd100);
        run_cmd("sum_shift2", OP_G_REDUCE_SUM, 16'h0700, 16'h0211, 16'd4, 16'd1, 16'd1, 16'd0, 5'd2, 1'b0);
        push_exp(16'h0212, 8'h80);
        run_cmd("sum_sat_lo", OP_G_REDUCE_SUM, 16'h0704, 16'h0212, 16'd4, 16'd1, 16'd1, 16'd0, 5'd0, 1'b0);

        // MEAN rounding half away from zero
        push_exp(16'h0220, 8'd1);
        push_exp(16'h0221, 8'hFF);
        run_cmd("mean_pm", OP_G_REDUCE_MEAN, 16'h0400, 16'h0220, 16'd3, 16'd2, 16'd1, 16'd3, 5'd0, 1'b0);
        push_exp(16'h0222, 8'd2);
        run_cmd("mean_half", OP_G_REDUCE_MEAN, 16'h0410, 16'h0222, 16'd2, 16'd1, 16'd1, 16'd0, 5'd0, 1'b0);

        // ARGMAX first maximum, MIN, MAX with address wrap
        push_exp(16'h0230, 8'd1);
        run_cmd("argmax", OP_G_REDUCE_ARGMAX, 16'h0500, 16'h0230, 16'd5, 16'd1, 16'd1, 16'd0, 5'd0, 1'b0);
        push_exp(16'h0231, 8'hFE);
        run_cmd("min", OP_G_REDUCE_MIN, 16'h0500, 16'h0231, 16'd5, 16'd1, 16'd1, 16'd0, 5'd0, 1'b0);
        push_exp(16'h0232, 8'd20);
        run_cmd("max_wrap", OP_G_REDUCE_MAX, 16'hFFFE, 16'h0232, 16'd3, 16'd1, 16'd2, 16'd0, 5'd0, 1'b0);

        // Illegal commands: err+done, no writes
        run_cmd("dim_zero", OP_G_REDUCE_SUM, 16'h0100, 16'h0240, 16'd0, 16'd1, 16'd1, 16'd0, 5'd0, 1'b1);
        run_cmd("rows_zero", OP_G_REDUCE_MAX, 16'h0100, 16'h0240, 16'd4, 16'd0, 16'd1, 16'd0, 5'd0, 1'b1);
        run_cmd("bad_opcode", 8'hFF, 16'h0100, 16'h0240, 16'd4, 16'd1, 16'd1, 16'd0, 5'd0, 1'b1);

        // Command while busy is ignored
        push_exp(16'h0250, 8'd10);
        push_exp(16'h0251, 8'hF6);
        d0 = done_cnt;
        start_cmd(OP_G_REDUCE_SUM, 16'h0100, 16'h0250, 16'd4, 16'd2, 16'd1, 16'd4, 5'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cmd_opcode   = OP_G_REDUCE_MAX;
            cmd_dst_base = 16'h0900;
            cmd_valid    = 1'b1;
            check("ready_low_busy", 32'(cmd_ready), 32'd0);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_done("busy_cmd", 1'b0);
        repeat (10) @(negedge clk);
        check("busy_cmd_one_done", 32'(done_cnt - d0), 32'd1);
        check("busy_cmd_idle", 32'(busy), 32'd0);

        // Reset in the middle of S_ISSUE
        d0 = done_cnt;
        start_cmd(OP_G_REDUCE_SUM, 16'h0300, 16'h0260, 16'd8, 16'd1, 16'd1, 16'd0, 5'd0);
        repeat (3) @(negedge clk);
        check("pre_reset_issue", 32'(sram_rd_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", {29'd0, cmd_ready, busy, sram_rd_en}, 32'b100);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("reset_no_done", 32'(done_cnt - d0), 32'd0);

        // Throughput: 3 rows of 8, shift 3
        push_exp(16'h0A00, 8'd5);
        push_exp(16'h0A01, 8'd13);
        push_exp(16'h0A02, 8'd21);
        @(negedge clk);
        busy_cyc = 0;
        rd_cyc   = 0;
        run_cmd("tput", OP_G_REDUCE_SUM, 16'h0300, 16'h0A00, 16'd8, 16'd3, 16'd1, 16'd8, 5'd3, 1'b0);
        check("tput_busy_cycles", 32'(busy_cyc), 32'd34);
        check("tput_rd_cycles", 32'(rd_cyc), 32'd24);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(exp_addr_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
